// File: rtl/mastermind_scorer.sv
// mastermind_scorer: sequential black/white peg scorer for a 4-position Mastermind code.
// Optional guess limit enabled by defining MM_GUESS_LIMIT_EN.
module mastermind_scorer #(
  parameter int COLOR_W = 3,
  parameter int MAX_GUESSES = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               load_code_1,
  input  logic               load_code_2,
  input  logic               load_code_3,
  input  logic               load_code_4,
  input  logic               load_guess_1,
  input  logic               load_guess_2,
  input  logic               load_guess_3,
  input  logic               load_guess_4,
  input  logic               compare,
  input  logic [1:0]         compare_i,
  input  logic               reach_result_3,
  output logic [2:0]         black,
  output logic [2:0]         white,
  output logic               result_valid,
  output logic               win,
  output logic [3:0]         guess_num,
  output logic               game_over
);
`ifdef MM_GUESS_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  logic [COLOR_W-1:0] code [4];
  logic [COLOR_W-1:0] guess [4];
  logic [3:0] ld_c, ld_g, exact, hit, sel, used, base_u, used_n, gn_n;
  logic [2:0] acc_b, acc_w, base_b, base_w, nb, nw;
  logic step, fin, ex_i;
  assign ld_c = {load_code_4, load_code_3, load_code_2, load_code_1};
  assign ld_g = {load_guess_4, load_guess_3, load_guess_2, load_guess_1};
  assign step = compare && !game_over;
  assign fin = step && reach_result_3;
  assign base_b = compare_i == 2'd0 ? 3'd0 : acc_b;
  assign base_w = compare_i == 2'd0 ? 3'd0 : acc_w;
  assign base_u = compare_i == 2'd0 ? 4'd0 : used;
  assign ex_i = exact[compare_i];
  always_comb begin
    exact = '0;
    hit = '0;
    for (int k = 0; k < 4; k++) begin
      exact[k] = code[k] == guess[k];
      hit[k] = !exact[k] && !base_u[k] && code[k] == guess[compare_i];
    end
  end
  // isolate lowest candidate code position
  assign sel = hit & (~hit + 4'd1);
  assign used_n = ex_i ? base_u : base_u | sel;
  assign nb = base_b + {2'b0, ex_i};
  assign nw = base_w + {2'b0, !ex_i && |hit};
  assign gn_n = guess_num + {3'b0, guess_num != 4'hf};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        code[k] <= '0;
        guess[k] <= '0;
      end
      acc_b <= '0;
      acc_w <= '0;
      used <= '0;
      black <= '0;
      white <= '0;
      result_valid <= 1'b0;
      win <= 1'b0;
      guess_num <= '0;
      game_over <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ld_c[k]) code[k] <= color_in;
        if (ld_g[k]) guess[k] <= color_in;
      end
      result_valid <= fin;
      if (step) begin
        acc_b <= nb;
        acc_w <= nw;
        used <= used_n;
      end
      if (fin) begin
        black <= nb;
        white <= nw;
        win <= nb == 3'd4;
        guess_num <= gn_n;
      end
      if (LIMIT && fin && (gn_n == 4'(MAX_GUESSES) || nb == 3'd4)) game_over <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mastermind_scorer.sv
// tb_mastermind_scorer: scoreboard bench for mastermind_scorer with directed vectors.
module tb_mastermind_scorer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [2:0] color_in = '0;
  logic [3:0] lc = '0, lg = '0;
  logic compare = 1'b0, reach = 1'b0;
  logic [1:0] ci = '0;
  logic [2:0] black, white;
  logic result_valid, win, game_over;
  logic [3:0] guess_num;
  typedef struct packed {logic [2:0] b; logic [2:0] w; logic win; logic [3:0] gn;} res_t;
  res_t q[$];
  int checks = 0, errors = 0;
  logic [3:0] exp_gn = '0;
  mastermind_scorer dut (
    .clk(clk), .resetn(resetn), .color_in(color_in),
    .load_code_1(lc[0]), .load_code_2(lc[1]), .load_code_3(lc[2]), .load_code_4(lc[3]),
    .load_guess_1(lg[0]), .load_guess_2(lg[1]), .load_guess_3(lg[2]), .load_guess_4(lg[3]),
    .compare(compare), .compare_i(ci), .reach_result_3(reach),
    .black(black), .white(white), .result_valid(result_valid), .win(win),
    .guess_num(guess_num), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (resetn && result_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        res_t e;
        e = q.pop_front();
        chk("black", int'(black), int'(e.b));
        chk("white", int'(white), int'(e.w));
        chk("win", int'(win), int'(e.win));
        chk("guess_num", int'(guess_num), int'(e.gn));
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] p(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction
  task automatic load(input logic [11:0] c, input logic [11:0] g);
    for (int k = 0; k < 4; k++) begin
      color_in = c[3*k +: 3];
      lc = 4'b1 << k;
      tick();
      color_in = g[3*k +: 3];
      lc = '0;
      lg = 4'b1 << k;
      tick();
      lg = '0;
    end
  endtask
  task automatic steps(input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      compare = 1'b1;
      ci = 2'(i);
      reach = fin && i == 3;
      tick();
    end
    compare = 1'b0;
    reach = 1'b0;
  endtask
  task automatic score(input logic [11:0] c, input logic [11:0] g, input int b, input int w);
    load(c, g);
    exp_gn = exp_gn == 4'hf ? exp_gn : exp_gn + 4'd1;
    q.push_back('{3'(b), 3'(w), b == 4, exp_gn});
    steps(4, 1'b1);
    tick();
    tick();
`ifdef MM_GUESS_LIMIT_EN
    if (b == 4) begin
      chk("game_over_win", int'(game_over), 1);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      exp_gn = '0;
    end
`endif
  endtask
  initial begin
    tick();
    tick();
    chk("rst_black", int'(black), 0);
    chk("rst_white", int'(white), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_gn", int'(guess_num), 0);
    chk("rst_go", int'(game_over), 0);
    resetn = 1'b1;
    tick();
    score(p(1,2,3,4), p(1,2,3,4), 4, 0);
    score(p(1,2,3,4), p(4,3,2,1), 0, 4);
    score(p(1,1,2,2), p(1,2,1,0), 1, 2);
    score(p(5,5,5,5), p(5,0,0,0), 1, 0);
    score(p(1,2,3,4), p(2,2,2,2), 1, 0);
    score(p(3,3,1,1), p(1,1,3,3), 0, 4);
    reach = 1'b1;
    tick();
    reach = 1'b0;
    tick();
    tick();
    chk("hold_black", int'(black), 0);
    chk("hold_white", int'(white), 4);
    chk("hold_gn", int'(guess_num), int'(exp_gn));
    load(p(1,2,3,4), p(1,2,3,4));
    steps(2, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_gn = '0;
    chk("mid_black", int'(black), 0);
    chk("mid_white", int'(white), 0);
    chk("mid_gn", int'(guess_num), 0);
    chk("mid_win", int'(win), 0);
    tick();
    tick();
    chk("mid_novalid", int'(result_valid), 0);
    score(p(1,2,3,4), p(1,2,4,3), 2, 2);
`ifdef MM_GUESS_LIMIT_EN
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_gn = '0;
    for (int n = 0; n < 10; n++) score(p(1,2,3,4), p(5,5,5,5), 0, 0);
    chk("limit_go", int'(game_over), 1);
    load(p(1,2,3,4), p(5,5,5,5));
    steps(4, 1'b1);
    tick();
    tick();
    chk("limit_gn", int'(guess_num), 10);
`endif
    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
